// File: rtl/data_mem_wait_responder_if.sv
// Load/store request/response bus between the datapath memory stage and the
// data-memory responder.
interface data_mem_wait_responder_if #(
   parameter int unsigned ADDR_W = 32
) ();

   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [2:0]        req_funct3;
   logic [31:0]       req_wdata;
   logic              resp_valid;
   logic              resp_ready;
   logic [31:0]       resp_rdata;
   logic              resp_err;

   // Datapath side: issues requests, consumes responses.
   modport master (
      output req_valid,
      output req_we,
      output req_addr,
      output req_funct3,
      output req_wdata,
      output resp_ready,
      input  req_ready,
      input  resp_valid,
      input  resp_rdata,
      input  resp_err
   );

   // Memory side: accepts requests, produces responses.
   modport slave (
      input  req_valid,
      input  req_we,
      input  req_addr,
      input  req_funct3,
      input  req_wdata,
      input  resp_ready,
      output req_ready,
      output resp_valid,
      output resp_rdata,
      output resp_err
   );

endinterface

// File: rtl/data_mem_wait_responder.sv
// Single-outstanding data-memory responder with a programmable stall. A request
// is captured in IDLE, waits out the latency in WAIT, and is committed (store)
// or sampled (load) on the edge that enters RESP. RESP holds the response until
// the datapath takes it.
module data_mem_wait_responder #(
   parameter int unsigned NUM_WORDS = 128,
   parameter int unsigned LATENCY   = 2,
   parameter int unsigned ADDR_W    = 32
) (
   input logic                      clk,
   input logic                      rst_n,
   data_mem_wait_responder_if.slave bus
);

   localparam int unsigned IdxW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam logic [3:0]  LatM1 = 4'(LATENCY - 1);
   localparam logic [ADDR_W-1:0] NumWordsW = ADDR_W'(NUM_WORDS);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StWait = 2'd1;
   localparam logic [1:0] StResp = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [2:0]        f3_q, f3_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              err_q, err_d;

   logic [31:0]       mem_q [NUM_WORDS];

   logic              accept;
   logic              enter_resp;

   // Transaction being decoded: live bus in IDLE (needed when LATENCY==1 commits
   // on the accepting edge), captured copy otherwise.
   logic              t_we;
   logic [ADDR_W-1:0] t_addr;
   logic [2:0]        t_f3;
   logic [31:0]       t_wdata;

   logic              f3_ok;
   logic              misaligned;
   logic              out_of_range;
   logic              bad_unsigned_store;
   logic              acc_err;
   logic [IdxW-1:0]   idx;
   logic [3:0]        be;
   logic [31:0]       wlane;
   logic [31:0]       rd_word;
   logic [31:0]       rd_shift;
   logic [31:0]       load_val;
   logic              do_write;

   assign accept     = (state_q == StIdle) && bus.req_valid;
   assign enter_resp = (accept && (LatM1 == 4'd0)) ||
                       ((state_q == StWait) && (cnt_q == 4'd1));

   assign bus.req_ready  = (state_q == StIdle);
   assign bus.resp_valid = (state_q == StResp);
   assign bus.resp_rdata = rdata_q;
   assign bus.resp_err   = err_q;

   // Select live or captured request fields for decode.
   always_comb begin
      if (state_q == StIdle) begin
         t_we    = bus.req_we;
         t_addr  = bus.req_addr;
         t_f3    = bus.req_funct3;
         t_wdata = bus.req_wdata;
      end else begin
         t_we    = we_q;
         t_addr  = addr_q;
         t_f3    = f3_q;
         t_wdata = wdata_q;
      end
   end

   // Decode access legality, byte lanes and the extended load value.
   always_comb begin
      f3_ok      = 1'b0;
      misaligned = 1'b0;
      be         = 4'b0000;
      wlane      = 32'h0;
      load_val   = 32'h0;
      idx        = t_addr[IdxW+1:2];
      rd_word    = mem_q[idx];
      rd_shift   = rd_word >> {t_addr[1:0], 3'b000};

      case (t_f3)
         3'b000, 3'b100: begin
            f3_ok = 1'b1;
            be    = 4'b0001 << t_addr[1:0];
            wlane = {4{t_wdata[7:0]}};
         end
         3'b001, 3'b101: begin
            f3_ok      = 1'b1;
            misaligned = t_addr[0];
            be         = t_addr[1] ? 4'b1100 : 4'b0011;
            wlane      = {2{t_wdata[15:0]}};
         end
         3'b010: begin
            f3_ok      = 1'b1;
            misaligned = (t_addr[1:0] != 2'b00);
            be         = 4'b1111;
            wlane      = t_wdata;
         end
         default: begin
            f3_ok = 1'b0;
         end
      endcase

      case (t_f3)
         3'b000:  load_val = {{24{rd_shift[7]}}, rd_shift[7:0]};
         3'b001:  load_val = {{16{rd_shift[15]}}, rd_shift[15:0]};
         3'b010:  load_val = rd_word;
         3'b100:  load_val = {24'h0, rd_shift[7:0]};
         3'b101:  load_val = {16'h0, rd_shift[15:0]};
         default: load_val = 32'h0;
      endcase

      // Range check uses the whole address so high bits never alias into memory.
      out_of_range       = ({2'b00, t_addr[ADDR_W-1:2]} >= NumWordsW);
      bad_unsigned_store = t_we && t_f3[2];
      acc_err            = !f3_ok || misaligned || out_of_range || bad_unsigned_store;
      do_write           = enter_resp && t_we && !acc_err;
   end

   // FSM, latency counter, request capture and response registers next state.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      addr_d  = addr_q;
      f3_d    = f3_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;

      case (state_q)
         StIdle: begin
            if (accept) begin
               we_d    = bus.req_we;
               addr_d  = bus.req_addr;
               f3_d    = bus.req_funct3;
               wdata_d = bus.req_wdata;
               cnt_d   = LatM1;
               state_d = (LatM1 != 4'd0) ? StWait : StResp;
            end
         end
         StWait: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = StResp;
            end
         end
         StResp: begin
            if (bus.resp_ready) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Response is latched once, on the edge entering RESP, and then held.
      if (enter_resp) begin
         err_d   = acc_err;
         rdata_d = (t_we || acc_err) ? 32'h0 : load_val;
      end
   end

   // Control and response state with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         f3_q    <= 3'b000;
         wdata_q <= 32'h0;
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         f3_q    <= f3_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Storage is not reset; stores write only their enabled byte lanes.
   always_ff @(posedge clk) begin
      if (do_write) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
               mem_q[idx][8*b +: 8] <= wlane[8*b +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_data_mem_wait_responder.sv
// Directed bench for data_mem_wait_responder: two instances (LATENCY 2 and 3)
// checked against a byte-array memory model and hand-computed literals.
module tb_data_mem_wait_responder;

   localparam int NW = 128;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        vld [2];
   logic        req_we;
   logic [31:0] req_addr;
   logic [2:0]  req_funct3;
   logic [31:0] req_wdata;
   logic        resp_ready;

   logic        rv [2];
   logic        rr [2];
   logic [31:0] rd [2];
   logic        re [2];

   logic [31:0] exp_rd [2];
   logic        exp_err [2];
   logic [7:0]  mm [2][NW*4];

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   data_mem_wait_responder_if #(.ADDR_W(32)) bus_a ();
   data_mem_wait_responder_if #(.ADDR_W(32)) bus_b ();

   assign bus_a.req_valid  = vld[0];
   assign bus_a.req_we     = req_we;
   assign bus_a.req_addr   = req_addr;
   assign bus_a.req_funct3 = req_funct3;
   assign bus_a.req_wdata  = req_wdata;
   assign bus_a.resp_ready = resp_ready;
   assign bus_b.req_valid  = vld[1];
   assign bus_b.req_we     = req_we;
   assign bus_b.req_addr   = req_addr;
   assign bus_b.req_funct3 = req_funct3;
   assign bus_b.req_wdata  = req_wdata;
   assign bus_b.resp_ready = resp_ready;

   assign rv[0] = bus_a.resp_valid;
   assign rr[0] = bus_a.req_ready;
   assign rd[0] = bus_a.resp_rdata;
   assign re[0] = bus_a.resp_err;
   assign rv[1] = bus_b.resp_valid;
   assign rr[1] = bus_b.req_ready;
   assign rd[1] = bus_b.resp_rdata;
   assign re[1] = bus_b.resp_err;

   data_mem_wait_responder #(.NUM_WORDS(NW), .LATENCY(2), .ADDR_W(32)) u_dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_a)
   );

   data_mem_wait_responder #(.NUM_WORDS(NW), .LATENCY(3), .ADDR_W(32)) u_dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_b)
   );

   function automatic int lat(input int s);
      return (s == 0) ? 2 : 3;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
      end
   endtask

   // Reference model: memory as a flat little-endian byte array.
   task automatic model_access(input int s, input logic we, input logic [31:0] addr,
                               input logic [2:0] f3, input logic [31:0] wd,
                               output logic err, output logic [31:0] r);
      int size;
      logic [31:0] v;
      size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      err = !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) ||
            ((addr % size) != 0) || ((addr / 4) >= NW) || (we && f3[2]);
      r = 32'h0;
      if (!err) begin
         if (we) begin
            for (int i = 0; i < size; i++) mm[s][int'(addr) + i] = wd[8*i +: 8];
         end else begin
            v = 32'h0;
            for (int i = 0; i < size; i++) v[8*i +: 8] = mm[s][int'(addr) + i];
            if (size == 1) r = f3[2] ? {24'h0, v[7:0]} : {{24{v[7]}}, v[7:0]};
            else if (size == 2) r = f3[2] ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
            else r = v;
         end
      end
   endtask

   // Whenever a response is presented it must match the model and block new requests.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int s = 0; s < 2; s++) begin
            if (rv[s]) begin
               chk("mon_rdata", rd[s], exp_rd[s]);
               chk("mon_err", {31'h0, re[s]}, {31'h0, exp_err[s]});
               chk("mon_ready_low", {31'h0, rr[s]}, 32'h0);
            end
         end
      end
   end

   task automatic txn(input int s, input logic we, input logic [31:0] addr,
                      input logic [2:0] f3, input logic [31:0] wd, input int hold,
                      input logic lit_en, input logic [31:0] lit_rd, input logic lit_err);
      logic e;
      logic [31:0] r;
      int edges;
      model_access(s, we, addr, f3, wd, e, r);
      exp_err[s] = e;
      exp_rd[s]  = r;
      if (lit_en) begin
         chk("lit_rdata", r, lit_rd);
         chk("lit_err", {31'h0, e}, {31'h0, lit_err});
      end
      @(negedge clk);
      req_we     = we;
      req_addr   = addr;
      req_funct3 = f3;
      req_wdata  = wd;
      resp_ready = (hold == 0);
      vld[s]     = 1'b1;
      chk("idle_ready", {31'h0, rr[s]}, 32'h1);
      @(posedge clk);
      #1;
      // Garbage on the request bus mid-transaction must be ignored.
      req_we     = ~we;
      req_addr   = addr ^ 32'h4;
      req_funct3 = 3'b010;
      req_wdata  = ~wd;
      edges = 1;
      while (!rv[s] && edges < 20) begin
         @(posedge clk);
         #1;
         edges++;
      end
      chk("latency", 32'(edges), 32'(lat(s)));
      chk("rdata", rd[s], r);
      chk("err", {31'h0, re[s]}, {31'h0, e});
      if (hold > 0) begin
         repeat (hold) begin
            @(posedge clk);
            #1;
            chk("held_valid", {31'h0, rv[s]}, 32'h1);
            chk("held_rdata", rd[s], r);
         end
         resp_ready = 1'b1;
      end
      vld[s] = 1'b0;
      @(posedge clk);
      #1;
      chk("resp_done", {31'h0, rv[s]}, 32'h0);
      chk("back_idle", {31'h0, rr[s]}, 32'h1);
   endtask

   initial begin
      vld[0] = 1'b0;
      vld[1] = 1'b0;
      req_we = 1'b0;
      req_addr = 32'h0;
      req_funct3 = 3'b010;
      req_wdata = 32'h0;
      resp_ready = 1'b1;
      exp_rd[0] = 32'h0;
      exp_rd[1] = 32'h0;
      exp_err[0] = 1'b0;
      exp_err[1] = 1'b0;
      #2;
      for (int s = 0; s < 2; s++) begin
         chk("rst_ready", {31'h0, rr[s]}, 32'h1);
         chk("rst_valid", {31'h0, rv[s]}, 32'h0);
         chk("rst_rdata", rd[s], 32'h0);
         chk("rst_err", {31'h0, re[s]}, 32'h0);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Word store/load and extended sub-word loads.
      txn(0, 1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 0, 1'b1, 32'h0, 1'b0);
      txn(0, 1'b0, 32'h10, 3'b010, 32'h0, 0, 1'b1, 32'hDEADBEEF, 1'b0);
      txn(0, 1'b0, 32'h13, 3'b000, 32'h0, 0, 1'b1, 32'hFFFFFFDE, 1'b0);
      txn(0, 1'b0, 32'h13, 3'b100, 32'h0, 0, 1'b1, 32'h000000DE, 1'b0);
      txn(0, 1'b0, 32'h12, 3'b001, 32'h0, 0, 1'b1, 32'hFFFFDEAD, 1'b0);
      txn(0, 1'b0, 32'h10, 3'b101, 32'h0, 0, 1'b1, 32'h0000BEEF, 1'b0);

      // Byte and halfword stores touch only their lanes.
      txn(0, 1'b1, 32'h11, 3'b000, 32'hFFFFFF55, 0, 1'b1, 32'h0, 1'b0);
      txn(0, 1'b0, 32'h10, 3'b010, 32'h0, 0, 1'b1, 32'hDEAD55EF, 1'b0);
      txn(0, 1'b1, 32'h12, 3'b001, 32'hABCD1234, 0, 1'b1, 32'h0, 1'b0);
      txn(0, 1'b0, 32'h10, 3'b010, 32'h0, 0, 1'b1, 32'h123455EF, 1'b0);

      // Faulting accesses, including faulting stores that must not write.
      txn(0, 1'b0, 32'h12, 3'b010, 32'h0, 0, 1'b1, 32'h0, 1'b1);
      txn(0, 1'b0, 32'h11, 3'b001, 32'h0, 0, 1'b1, 32'h0, 1'b1);
      txn(0, 1'b0, 32'h10, 3'b011, 32'h0, 0, 1'b1, 32'h0, 1'b1);
      txn(0, 1'b0, NW * 4, 3'b010, 32'h0, 0, 1'b1, 32'h0, 1'b1);
      txn(0, 1'b1, 32'h10, 3'b100, 32'h0, 0, 1'b1, 32'h0, 1'b1);
      txn(0, 1'b1, 32'h80000010, 3'b010, 32'h0, 0, 1'b1, 32'h0, 1'b1);
      txn(0, 1'b1, 32'h12, 3'b010, 32'h0, 0, 1'b1, 32'h0, 1'b1);
      txn(0, 1'b0, 32'h10, 3'b010, 32'h0, 0, 1'b1, 32'h123455EF, 1'b0);

      // Last word in range.
      txn(0, 1'b1, NW * 4 - 4, 3'b010, 32'hAABBCCDD, 0, 1'b1, 32'h0, 1'b0);
      txn(0, 1'b0, NW * 4 - 4, 3'b010, 32'h0, 0, 1'b1, 32'hAABBCCDD, 1'b0);

      // Backpressure: response held for 5 cycles with a competing request.
      txn(0, 1'b0, 32'h10, 3'b010, 32'h0, 5, 1'b1, 32'h123455EF, 1'b0);

      // LATENCY=3 instance.
      txn(1, 1'b1, 32'h20, 3'b010, 32'h11111111, 0, 1'b1, 32'h0, 1'b0);
      txn(1, 1'b0, 32'h20, 3'b000, 32'h0, 2, 1'b1, 32'h00000011, 1'b0);

      // Reset during WAIT aborts the store.
      @(negedge clk);
      req_we = 1'b1;
      req_addr = 32'h20;
      req_funct3 = 3'b010;
      req_wdata = 32'hCAFEF00D;
      resp_ready = 1'b1;
      vld[1] = 1'b1;
      @(posedge clk);
      #1;
      vld[1] = 1'b0;
      chk("abort_accepted", {31'h0, rr[1]}, 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort_valid", {31'h0, rv[1]}, 32'h0);
      chk("abort_ready", {31'h0, rr[1]}, 32'h1);
      chk("abort_rdata", rd[1], 32'h0);
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("abort_no_resp", {31'h0, rv[1]}, 32'h0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      txn(1, 1'b0, 32'h20, 3'b010, 32'h0, 0, 1'b1, 32'h11111111, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global time bound so the run always terminates.
   initial begin
      #200000;
      failures++;
      $display("FAIL timeout actual=running required=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
